pwm_multi: RTL and testbench

- Parametrised, multi-channel successor to the single-channel PWM generator.
- NUM_CH outputs share one period counter, each with its own duty compare, so outputs stay phase-aligned.
- Supports continuous mode, and burst mode with a programmable pulse count (1..256) instead of a fixed 8/16.
- Period, duty and enables are double-buffered and reload only at period boundaries, so output pulses never glitch.

---
 rtl/pwm_multi.sv | 129 ++++++++++++
 tb/tb_pwm_multi.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// pwm_multi: NUM_CH phase-aligned PWM outputs driven from one shared period
// counter. It runs continuously or in bursts of 1..256 periods. Period, duty
// and enables are double-buffered and take effect only at period boundaries.
//
// Control pulses: start and stop are single-cycle strobes with no handshake.
// start is taken only in IDLE, when stop is low and period >= 2. stop aborts
// immediately from any busy state and takes priority over start.
module pwm_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CNT_W-1:0]        period,
  input  logic [NUM_CH*CNT_W-1:0] duty,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    burst_en,
  input  logic [7:0]              burst_len,
  input  logic                    start,
  input  logic                    stop,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_tick,
  output logic                    busy,
  output logic                    burst_done,
  output logic [1:0]              stateDbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t state, stateNext;

  logic [CNT_W-1:0]        cnt, cntNext;
  logic [CNT_W-1:0]        perSh, perNext;
  logic [NUM_CH*CNT_W-1:0] dutySh, dutyNext;
  logic [NUM_CH-1:0]       enSh, enNext;
  logic [7:0]              lenSh;
  logic [8:0]              pulseCnt, pulseNext;
  logic [8:0]              lenFull;
  logic [NUM_CH-1:0]       pwmNext;
  logic                    doneNext;

  logic periodOk;
  logic startOk;
  logic wrap;
  logic burstEnd;
  logic loadNow;

  // Qualified control events shared by the FSM and the datapath.
  assign periodOk = (period >= CNT_W'(2));
  assign startOk  = (state == IDLE) && start && !stop && periodOk;
  assign wrap     = (state != IDLE) && (cnt == perSh - 1'b1);
  assign lenFull  = (lenSh == 8'd0) ? 9'd256 : {1'b0, lenSh};
  assign burstEnd = (state == BURST) && wrap && ((pulseCnt + 9'd1) == lenFull);
  assign loadNow  = startOk || (wrap && !stop);

  assign busy        = (state != IDLE);
  assign period_tick = wrap;
  assign stateDbg    = state;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (startOk) stateNext = burst_en ? BURST : RUN;
      RUN:     if (stop) stateNext = IDLE;
      BURST:   if (stop || burstEnd) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Next values for the counter and shadow registers; an illegal period at a
  // wrap keeps the previous period so a running output never stalls.
  always_comb begin
    perNext   = (loadNow && periodOk) ? period : perSh;
    dutyNext  = loadNow ? duty : dutySh;
    enNext    = loadNow ? ch_en : enSh;
    cntNext   = '0;
    pulseNext = '0;
    if (stateNext != IDLE && !startOk) begin
      cntNext   = wrap ? '0 : cnt + 1'b1;
      pulseNext = wrap ? pulseCnt + 9'd1 : pulseCnt;
    end
  end

  // Output logic: outputs follow the counter value that will hold after this
  // edge, so the first high sample lands on the start edge itself.
  always_comb begin
    pwmNext  = '0;
    doneNext = burstEnd && !stop;
    for (int i = 0; i < NUM_CH; i++) begin
      pwmNext[i] = (stateNext != IDLE) && enNext[i] &&
                   (cntNext < dutyNext[i*CNT_W +: CNT_W]);
    end
  end

  // Datapath registers: counter, shadows and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      pulseCnt   <= '0;
      perSh      <= '0;
      dutySh     <= '0;
      enSh       <= '0;
      lenSh      <= '0;
      pwm_out    <= '0;
      burst_done <= 1'b0;
    end else begin
      cnt        <= cntNext;
      pulseCnt   <= pulseNext;
      perSh      <= perNext;
      dutySh     <= dutyNext;
      enSh       <= enNext;
      pwm_out    <= pwmNext;
      burst_done <= doneNext;
      if (startOk) lenSh <= burst_len;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed and randomized checks of pwm_multi against a
// waveform model computed from cycle index, period, duty and burst length.
module tb_pwm_multi;

  localparam int NCH = 4;
  localparam int CW  = 16;

  logic              clk;
  logic              rst;
  logic [CW-1:0]     period;
  logic [NCH*CW-1:0] duty;
  logic [NCH-1:0]    ch_en;
  logic              burst_en;
  logic [7:0]        burst_len;
  logic              start;
  logic              stop;
  logic [NCH-1:0]    pwm_out;
  logic              period_tick;
  logic              busy;
  logic              burst_done;
  logic [1:0]        state_dbg;

  int compared   = 0;
  int mismatched = 0;

  // Reference configuration for the model.
  int         m_per;
  int         m_duty[NCH];
  logic [3:0] m_en;
  logic       m_burst;
  int         m_len;
  string      cur_test;

  pwm_multi #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .period(period), .duty(duty), .ch_en(ch_en),
    .burst_en(burst_en), .burst_len(burst_len), .start(start), .stop(stop),
    .pwm_out(pwm_out), .period_tick(period_tick), .busy(busy),
    .burst_done(burst_done), .stateDbg(state_dbg)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers.
  task automatic apply_cfg();
    period    = CW'(m_per);
    for (int i = 0; i < NCH; i++) duty[i*CW +: CW] = CW'(m_duty[i]);
    ch_en     = m_en;
    burst_en  = m_burst;
    burst_len = 8'(m_len);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " pwm"},  32'(pwm_out), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " tick"}, 32'(period_tick), 32'd0);
  endtask

  // Model: k counts cycles after the start edge (k=0 is the start edge).
  task automatic check_cycle(input int k);
    logic [3:0] ep;
    logic eb, et, ed;
    int pos, total;
    total = m_len * m_per;
    ep = '0; eb = 1'b0; et = 1'b0; ed = 1'b0;
    if (!m_burst || k < total) begin
      pos = k % m_per;
      eb  = 1'b1;
      et  = (pos == m_per - 1);
      for (int i = 0; i < NCH; i++) ep[i] = m_en[i] && (pos < m_duty[i]);
    end else begin
      ed = (k == total);
    end
    chk($sformatf("%s k=%0d pwm", cur_test, k),  32'(pwm_out), 32'(ep));
    chk($sformatf("%s k=%0d busy", cur_test, k), 32'(busy), 32'(eb));
    chk($sformatf("%s k=%0d tick", cur_test, k), 32'(period_tick), 32'(et));
    chk($sformatf("%s k=%0d done", cur_test, k), 32'(burst_done), 32'(ed));
  endtask

  task automatic run_model(input int n);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      check_cycle(k);
    end
  endtask

  int ones0, ones1;

  initial begin
    rst = 1'b0; period = '0; duty = '0; ch_en = '0; burst_en = 1'b0;
    burst_len = '0; start = 1'b0; stop = 1'b0;
    m_len = 1;

    // Reset state.
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset done", 32'(burst_done), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Continuous, duty {0,3,10,12}; a start while busy and an illegal period
    // at a later wrap must both leave the waveform untouched.
    cur_test = "cont";
    m_per = 10; m_duty = '{0, 3, 10, 12}; m_en = 4'hF; m_burst = 1'b0;
    apply_cfg();
    pulse_start();
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      check_cycle(k);
      start = (k == 13);
      if (k == 15) period = CW'(1);
    end
    start = 1'b0;
    pulse_stop();
    chk_idle("cont stop");

    // Burst of 3 periods of 5, duty0 = 2.
    cur_test = "burst3";
    m_per = 5; m_duty = '{2, 0, 0, 0}; m_en = 4'hF; m_burst = 1'b1; m_len = 3;
    apply_cfg();
    pulse_start();
    run_model(20);

    // Shadow reload: duty0 3 -> 7 at cnt=4.
    cur_test = "reload";
    m_per = 10; m_duty = '{3, 0, 0, 0}; m_en = 4'h1; m_burst = 1'b0;
    apply_cfg();
    pulse_start();
    ones0 = 0; ones1 = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 10) ones0 += int'(pwm_out[0]);
      else        ones1 += int'(pwm_out[0]);
      if (k == 4) duty[0 +: CW] = CW'(7);
    end
    chk("reload first period", 32'(ones0), 32'd3);
    chk("reload second period", 32'(ones1), 32'd7);
    pulse_stop();
    chk_idle("reload stop");

    // burst_len = 0 means 256 periods.
    cur_test = "burst256";
    m_per = 2; m_duty = '{1, 0, 0, 0}; m_en = 4'h1; m_burst = 1'b1; m_len = 256;
    apply_cfg();
    pulse_start();
    run_model(515);

    // Illegal period on start.
    m_per = 1; m_burst = 1'b0;
    apply_cfg();
    pulse_start();
    chk_idle("per1 start");
    @(negedge clk);
    chk_idle("per1 later");

    // Stop mid-burst.
    cur_test = "stopburst";
    m_per = 6; m_duty = '{3, 6, 0, 1}; m_en = 4'hF; m_burst = 1'b1; m_len = 4;
    apply_cfg();
    pulse_start();
    run_model(8);
    pulse_stop();
    chk_idle("stopburst edge");
    chk("stopburst done", 32'(burst_done), 32'd0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("stopburst quiet done", 32'(burst_done), 32'd0);
    end
    chk("stopburst quiet busy", 32'(busy), 32'd0);

    // start and stop together.
    m_per = 4; m_burst = 1'b0;
    apply_cfg();
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk_idle("start+stop");

    // Reset mid-run, then restart from cnt=0.
    cur_test = "rstrun";
    m_per = 7; m_duty = '{4, 2, 7, 0}; m_en = 4'hB; m_burst = 1'b0;
    apply_cfg();
    pulse_start();
    run_model(8);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("midrst");
    chk("midrst done", 32'(burst_done), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    cur_test = "restart";
    pulse_start();
    run_model(16);
    pulse_stop();

    // Randomized configurations.
    for (int r = 0; r < 8; r++) begin
      cur_test = $sformatf("rand%0d", r);
      m_per   = $urandom_range(2, 9);
      for (int i = 0; i < NCH; i++) m_duty[i] = $urandom_range(0, 11);
      m_en    = 4'($urandom_range(0, 15));
      m_burst = 1'($urandom_range(0, 1));
      m_len   = $urandom_range(1, 3);
      apply_cfg();
      pulse_start();
      if (m_burst) begin
        run_model(m_len * m_per + 3);
      end else begin
        run_model(3 * m_per);
        pulse_stop();
        chk_idle({cur_test, " stop"});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
